ether_tx: RTL and testbench

Transmit-side Ethernet framer: it is the counterpart of the receive deframer and sits between the KVS application's reply stream and the CMAC TX interface. It takes a 512-bit payload bitstream and a 112-bit Ethernet header, then emits a 512-bit bitstream with the 14-byte header prepended. Downstream data is re-aligned by 14 bytes across beat boundaries. MAC addresses are optionally swapped so a reply returns to the requester. Ready/valid backpressure is honoured on both sides.

---
 rtl/ether_tx_if.sv | 26 ++
 rtl/ether_tx.sv | 109 ++++++++++
 tb/tb_ether_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ether_tx_if.sv
// rtl/ether_tx_if.sv - payload/header input stream and framed output stream of ether_tx
interface ether_tx_if;
   logic [111:0] hdr_data;
   logic [511:0] send_data;
   logic         send_valid;
   logic         send_sop;
   logic         send_eop;
   logic [7:0]   send_mty;
   logic         send_ready;
   logic [511:0] out_data;
   logic         out_valid;
   logic         out_sop;
   logic         out_eop;
   logic [7:0]   out_mty;
   logic         out_ready;

   modport master (
      output hdr_data, send_data, send_valid, send_sop, send_eop, send_mty, out_ready,
      input  send_ready, out_data, out_valid, out_sop, out_eop, out_mty
   );

   modport slave (
      input  hdr_data, send_data, send_valid, send_sop, send_eop, send_mty, out_ready,
      output send_ready, out_data, out_valid, out_sop, out_eop, out_mty
   );
endinterface

// File: rtl/ether_tx.sv
// rtl/ether_tx.sv - Ethernet TX framer: prepends a 14-byte header and realigns payload by 14 bytes
module ether_tx #(
   parameter bit          SWAP_MAC   = 1'b1,
   parameter logic [15:0] ETHER_TYPE = 16'h6000
) (
   input  logic        clk,
   input  logic        reset_n,
   ether_tx_if.slave   bus,
   output logic [15:0] frame_count,
   output logic [15:0] drop_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BODY  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   logic [1:0]   state;
   logic [111:0] carry;
   logic [7:0]   carry_mty;
   logic [511:0] out_data_q;
   logic         out_valid_q;
   logic         out_sop_q;
   logic         out_eop_q;
   logic [7:0]   out_mty_q;
   logic         load;
   logic         send_ready;
   logic         in_fire;
   logic         out_fire;
   logic [111:0] hdr_out;

   assign load       = !out_valid_q || bus.out_ready;
   assign send_ready = load && (state != FLUSH);
   assign in_fire    = bus.send_valid && send_ready;
   assign out_fire   = out_valid_q && bus.out_ready;

   assign hdr_out = SWAP_MAC ? {bus.hdr_data[63:16], bus.hdr_data[111:64], ETHER_TYPE}
                             : {bus.hdr_data[111:16], ETHER_TYPE};

   assign bus.send_ready = send_ready;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sop    = out_sop_q;
   assign bus.out_eop    = out_eop_q;
   assign bus.out_mty    = out_mty_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         carry       <= '0;
         carry_mty   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_mty_q   <= '0;
         frame_count <= '0;
         drop_count  <= '0;
      end else begin
         // A consumed beat drops valid unless a new beat loads below on the same edge.
         if (out_fire)
            out_valid_q <= 1'b0;
         if (out_fire && out_eop_q)
            frame_count <= frame_count + 16'd1;

         case (state)
            IDLE, BODY: begin
               if (in_fire) begin
                  if (state == IDLE && !bus.send_sop) begin
                     if (drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                  end else begin
                     out_data_q  <= {(state == IDLE) ? hdr_out : carry, bus.send_data[511:112]};
                     out_sop_q   <= (state == IDLE);
                     out_valid_q <= 1'b1;
                     carry       <= bus.send_data[111:0];
                     if (!bus.send_eop) begin
                        out_eop_q <= 1'b0;
                        out_mty_q <= '0;
                        state     <= BODY;
                     end else if (bus.send_mty >= 8'd14) begin
                        out_eop_q <= 1'b1;
                        out_mty_q <= bus.send_mty - 8'd14;
                        state     <= IDLE;
                     end else begin
                        // Tail bytes do not fit: the 14 carried bytes go out in a FLUSH beat.
                        out_eop_q <= 1'b0;
                        out_mty_q <= '0;
                        carry_mty <= bus.send_mty + 8'd50;
                        state     <= FLUSH;
                     end
                  end
               end
            end
            FLUSH: begin
               if (load) begin
                  out_data_q  <= {carry, 400'd0};
                  out_sop_q   <= 1'b0;
                  out_eop_q   <= 1'b1;
                  out_mty_q   <= carry_mty;
                  out_valid_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ether_tx.sv
// tb/tb_ether_tx.sv - directed and randomized checks of ether_tx against a byte-stream model
module tb_ether_tx;

   typedef struct packed {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic [7:0]   mty;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] frame_count;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   ether_tx_if bus ();

   ether_tx #(.SWAP_MAC(1'b1), .ETHER_TYPE(16'h6000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .frame_count (frame_count),
      .drop_count  (drop_count)
   );

   int     errors = 0;
   int     checks = 0;
   beat_t  obs_q[$];
   beat_t  exp_q[$];
   int     ready_mode = 0;
   int     rdy_idx = 0;
   int     busy_cycles = 0;
   bit     stalled_prev = 1'b0;
   beat_t  held;
   int     exp_frames = 0;
   int     exp_drops = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: called at a negedge with inputs set; samples 1ns later, returns at the next negedge.
   task automatic cycle(output bit acc);
      beat_t cur;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       begin bus.out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3); rdy_idx++; end
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      cur = '{bus.out_data, bus.out_sop, bus.out_eop, bus.out_mty};
      if (stalled_prev) begin
         chk("hold_data", cur.data, held.data);
         chk("hold_ctl", {cur.sop, cur.eop, cur.mty}, {held.sop, held.eop, held.mty});
      end
      if (bus.out_valid && !bus.out_ready)
         chk("ready_in_stall", bus.send_ready, 1'b0);
      if (!bus.send_ready && bus.out_ready)
         busy_cycles++;
      if (bus.out_valid && bus.out_ready)
         obs_q.push_back(cur);
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = cur;
      acc = bus.send_valid && bus.send_ready;
      @(negedge clk);
   endtask

   // Reference: the frame is one byte stream (header then every input byte) cut into 64-byte beats.
   task automatic model(input logic [111:0] hdr, input logic [511:0] beats[$], input logic [7:0] mty);
      logic [7:0] s[$];
      int total, nout;
      beat_t b;
      for (int i = 0; i < 6; i++) s.push_back(hdr[63 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) s.push_back(hdr[111 - 8*i -: 8]);
      s.push_back(8'h60);
      s.push_back(8'h00);
      foreach (beats[k])
         for (int i = 0; i < 64; i++) s.push_back(beats[k][511 - 8*i -: 8]);
      total = 14 + 64 * beats.size() - int'(mty);
      nout = (total + 63) / 64;
      for (int k = 0; k < nout; k++) begin
         for (int j = 0; j < 64; j++)
            b.data[511 - 8*j -: 8] = (64*k + j < s.size()) ? s[64*k + j] : 8'h00;
         b.sop = (k == 0);
         b.eop = (k == nout - 1);
         b.mty = b.eop ? 8'(64 * nout - total) : 8'd0;
         exp_q.push_back(b);
      end
      exp_frames++;
   endtask

   task automatic send_frame(input logic [111:0] hdr, input int n, input logic [7:0] mty,
                             input bit ramp, input int gap_pct);
      logic [511:0] beats[$];
      logic [511:0] d;
      bit acc;
      int guard;
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < 64; i++)
            d[511 - 8*i -: 8] = ramp ? 8'(64*b + i) : 8'($urandom);
         beats.push_back(d);
      end
      model(hdr, beats, mty);
      for (int b = 0; b < n; b++) begin
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.send_valid = 1'b0;
            cycle(acc);
         end
         bus.hdr_data   = (b == 0) ? hdr : 112'($urandom);
         bus.send_data  = beats[b];
         bus.send_valid = 1'b1;
         bus.send_sop   = (b == 0);
         bus.send_eop   = (b == n - 1);
         bus.send_mty   = (b == n - 1) ? mty : 8'($urandom_range(0, 63));
         guard = 0;
         acc = 1'b0;
         while (!acc && guard < 200) begin
            cycle(acc);
            guard++;
         end
         if (!acc) chk("send_timeout", 1'b0, 1'b1);
      end
      bus.send_valid = 1'b0;
      bus.send_sop   = 1'b0;
      bus.send_eop   = 1'b0;
   endtask

   task automatic stray();
      bit acc;
      int guard = 0;
      bus.send_data  = {16{$urandom}};
      bus.send_valid = 1'b1;
      bus.send_sop   = 1'b0;
      bus.send_eop   = 1'($urandom_range(0, 1));
      acc = 1'b0;
      while (!acc && guard < 200) begin
         cycle(acc);
         guard++;
      end
      if (!acc) chk("stray_timeout", 1'b0, 1'b1);
      exp_drops++;
      bus.send_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int guard = 0;
      bus.send_valid = 1'b0;
      while ((bus.out_valid || !bus.send_ready) && guard < 200) begin
         cycle(acc);
         guard++;
      end
      if (guard >= 200) chk("drain_timeout", 1'b0, 1'b1);
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_beats"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         chk({tag, "_data"}, obs_q[k].data, exp_q[k].data);
         chk({tag, "_ctl"}, {obs_q[k].sop, obs_q[k].eop, obs_q[k].mty},
                            {exp_q[k].sop, exp_q[k].eop, exp_q[k].mty});
      end
      chk({tag, "_frames"}, frame_count, 16'(exp_frames));
      chk({tag, "_drops"}, drop_count, 16'(exp_drops));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [111:0] h1;
      logic [511:0] e1;
      logic [127:0] r;
      bit acc;

      bus.hdr_data   = '0;
      bus.send_data  = '0;
      bus.send_valid = 1'b0;
      bus.send_sop   = 1'b0;
      bus.send_eop   = 1'b0;
      bus.send_mty   = '0;
      bus.out_ready  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data", bus.out_data, 512'd0);
      chk("rst_ctl", {bus.out_sop, bus.out_eop, bus.out_mty}, 10'd0);
      chk("rst_counts", {frame_count, drop_count}, 32'd0);
      chk("rst_ready", bus.send_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Single beat, mty=20: one output beat carrying swapped MACs and the fixed EtherType.
      h1 = {48'h111111111111, 48'h222222222222, 16'h0800};
      e1 = {48'h222222222222, 48'h111111111111, 16'h6000, 400'd0};
      for (int i = 0; i < 50; i++) e1[399 - 8*i -: 8] = 8'(i);
      ready_mode = 0;
      send_frame(h1, 1, 8'd20, 1'b1, 0);
      drain();
      if (obs_q.size() > 0) begin
         chk("t1_data", obs_q[0].data, e1);
         chk("t1_ctl", {obs_q[0].sop, obs_q[0].eop, obs_q[0].mty}, {1'b1, 1'b1, 8'd6});
      end else
         chk("t1_present", 1'b0, 1'b1);
      compare("t1");

      // Single beat, mty=0: a FLUSH beat follows and send_ready drops for one cycle.
      busy_cycles = 0;
      send_frame(h1, 1, 8'd0, 1'b1, 0);
      drain();
      chk("t2_ready_gap", busy_cycles, 1);
      compare("t2");

      send_frame(h1, 3, 8'd14, 1'b1, 0);
      drain();
      compare("t3");

      ready_mode = 1;
      rdy_idx = 0;
      send_frame(h1, 3, 8'd14, 1'b1, 0);
      drain();
      compare("t4_stall");

      ready_mode = 0;
      stray();
      stray();
      send_frame(h1, 2, 8'd5, 1'b0, 0);
      drain();
      compare("t5_stray");

      // Reset after the first of three beats: outputs clear at once, partial frame is lost.
      bus.hdr_data   = h1;
      bus.send_data  = {16{$urandom}};
      bus.send_valid = 1'b1;
      bus.send_sop   = 1'b1;
      bus.send_eop   = 1'b0;
      cycle(acc);
      chk("t6_accepted", acc, 1'b1);
      bus.send_sop = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", bus.out_valid, 1'b0);
      chk("t6_rst_data", bus.out_data, 512'd0);
      chk("t6_rst_ctl", {bus.out_sop, bus.out_eop, bus.out_mty}, 10'd0);
      chk("t6_rst_counts", {frame_count, drop_count}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.send_valid = 1'b0;
      stalled_prev = 1'b0;
      obs_q.delete();
      exp_q.delete();
      exp_frames = 0;
      exp_drops = 0;
      #1;
      chk("t6_ready", bus.send_ready, 1'b1);
      @(negedge clk);
      send_frame(h1, 3, 8'd30, 1'b0, 0);
      drain();
      compare("t6");

      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 4) == 0) stray();
         r = {$urandom, $urandom, $urandom, $urandom};
         send_frame(r[111:0], int'($urandom_range(1, 4)), 8'($urandom_range(0, 63)), 1'b0, 20);
         if ($urandom_range(0, 1) == 0) begin
            drain();
            compare("rnd");
         end
      end
      drain();
      compare("rnd_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
